// File: rtl/mux_pkg.sv
// Shared definitions for the round-robin N-to-1 mux.
// Provides the grant-mode encoding and the index-width helper.
package mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // A single channel still needs a 1-bit index.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter.
// req: requests, ptr: last winner, en: enable.
// gnt_onehot/gnt_idx/gnt_valid: the winner.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = idx_w(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N_CH-1:0]  gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  // Search offsets 1..N_CH past ptr; the
  // modulo keeps the wrap right for any N_CH.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_valid  = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      for (int i = 0; i < N_CH; i++) begin
        if (en && !gnt_valid && req[i] &&
            ((int'(ptr) + k) % N_CH == i)) begin
          gnt_valid     = 1'b1;
          gnt_idx       = SEL_W'(i);
          gnt_onehot[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mux_rr_nx1.sv
// Registered N-to-1 valid/ready mux, round-robin or fixed select.
// clk/rst: clock, sync active-high reset. mode/fix_sel: grant mode.
// in_data/in_valid/in_ready: input channels.
// out_data/out_sel/out_valid/out_ready: registered output.
module mux_rr_nx1
  import mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  localparam int SEL_W = idx_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      fix_sel,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] winner;
  logic [N_CH-1:0]  rr_oh;
  logic [N_CH-1:0]  fix_oh;
  logic [N_CH-1:0]  gnt_oh;
  logic             rr_vld;
  logic             fix_vld;
  logic             grant_valid;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] win_data;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req        (in_valid),
    .ptr        (rr_ptr),
    .en         (mode == MODE_RR),
    .gnt_onehot (rr_oh),
    .gnt_idx    (rr_idx),
    .gnt_valid  (rr_vld)
  );

  // Out-of-range fix_sel matches no channel,
  // so it simply yields no grant.
  always_comb begin
    fix_oh  = '0;
    fix_vld = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (fix_sel == SEL_W'(i) && in_valid[i]) begin
        fix_oh[i] = 1'b1;
        fix_vld   = 1'b1;
      end
    end
  end

  always_comb begin
    load = !out_valid || out_ready;
    if (mode == MODE_FIXED) begin
      grant_valid = fix_vld;
      winner      = fix_sel;
      gnt_oh      = fix_oh;
    end else begin
      grant_valid = rr_vld;
      winner      = rr_idx;
      gnt_oh      = rr_oh;
    end
    xfer     = load && grant_valid && !rst;
    in_ready = xfer ? gnt_oh : '0;
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_oh[i]) begin
        win_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= SEL_W'(N_CH - 1);
    end else if (load) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_sel   <= winner;
        if (mode == MODE_RR) begin
          rr_ptr <= winner;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Scoreboard bench for mux_rr_nx1 (4x8 and 3x16 instances).
// Stimulus pushes expected beats; monitors pop on output transfer.
module tb_mux_rr_nx1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 4-channel, 8-bit instance
  logic        rst4, mode4, ov4, or4;
  logic [1:0]  fsel4, os4;
  logic [31:0] din4;
  logic [3:0]  iv4, ir4;
  logic [7:0]  od4;

  // 3-channel, 16-bit instance
  logic        rst3, mode3, ov3, or3;
  logic [1:0]  fsel3, os3;
  logic [47:0] din3;
  logic [2:0]  iv3, ir3;
  logic [15:0] od3;

  logic [9:0]  q4[$];
  logic [17:0] q3[$];

  mux_rr_nx1 #(.N_CH(4), .WIDTH(8)) u4 (
    .clk(clk), .rst(rst4), .mode(mode4), .fix_sel(fsel4),
    .in_data(din4), .in_valid(iv4), .in_ready(ir4),
    .out_data(od4), .out_sel(os4), .out_valid(ov4),
    .out_ready(or4)
  );

  mux_rr_nx1 #(.N_CH(3), .WIDTH(16)) u3 (
    .clk(clk), .rst(rst3), .mode(mode3), .fix_sel(fsel3),
    .in_data(din3), .in_valid(iv3), .in_ready(ir3),
    .out_data(od3), .out_sel(os3), .out_valid(ov3),
    .out_ready(or3)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst4 && ov4 === 1'b1 && or4 === 1'b1) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out4_unexpected actual=%0h required=none",
                 {os4, od4});
      end else begin
        chk("out4_beat", {22'd0, os4, od4}, {22'd0, q4.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst3 && ov3 === 1'b1 && or3 === 1'b1) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out3_unexpected actual=%0h required=none",
                 {os3, od3});
      end else begin
        chk("out3_beat", {14'd0, os3, od3}, {14'd0, q3.pop_front()});
      end
    end
  end

  task automatic cyc4(input logic [3:0] er, input bit push,
                      input logic [1:0] s, input logic [7:0] d);
    #1 chk("in_ready4", {28'd0, ir4}, {28'd0, er});
    if (push) q4.push_back({s, d});
    @(posedge clk);
    #1;
  endtask

  task automatic cyc3(input logic [2:0] er, input bit push,
                      input logic [1:0] s, input logic [15:0] d);
    #1 chk("in_ready3", {29'd0, ir3}, {29'd0, er});
    if (push) q3.push_back({s, d});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst4 = 1'b1; mode4 = 1'b0; fsel4 = 2'd0; or4 = 1'b0;
    din4 = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; iv4 = 4'b1111;
    rst3 = 1'b1; mode3 = 1'b0; fsel3 = 2'd0; or3 = 1'b0;
    din3 = {16'hB002, 16'hB001, 16'hB000}; iv3 = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid4", {31'd0, ov4}, 32'd0);
    chk("rst_data4", {24'd0, od4}, 32'd0);
    chk("rst_sel4", {30'd0, os4}, 32'd0);
    chk("rst_ready4", {28'd0, ir4}, 32'd0);
    chk("rst_ready3", {29'd0, ir3}, 32'd0);

    // round-robin, all valid
    rst4 = 1'b0; or4 = 1'b1;
    cyc4(4'b0001, 1, 2'd0, 8'hA0);
    cyc4(4'b0010, 1, 2'd1, 8'hA1);
    cyc4(4'b0100, 1, 2'd2, 8'hA2);
    cyc4(4'b1000, 1, 2'd3, 8'hA3);
    cyc4(4'b0001, 1, 2'd0, 8'hA0);

    // sparse requests 1 and 3
    iv4 = 4'b1010;
    cyc4(4'b0010, 1, 2'd1, 8'hA1);
    cyc4(4'b1000, 1, 2'd3, 8'hA3);
    cyc4(4'b0010, 1, 2'd1, 8'hA1);
    cyc4(4'b1000, 1, 2'd3, 8'hA3);

    // backpressure on a held A2 beat
    iv4 = 4'b0100;
    cyc4(4'b0100, 1, 2'd2, 8'hA2);
    or4 = 1'b0; iv4 = 4'b1111;
    for (int n = 0; n < 3; n++) begin
      chk("hold_valid", {31'd0, ov4}, 32'd1);
      chk("hold_data", {24'd0, od4}, 32'hA2);
      cyc4(4'b0000, 0, 2'd0, 8'h00);
    end
    or4 = 1'b1;
    cyc4(4'b1000, 1, 2'd3, 8'hA3);

    // fixed select channel 2
    mode4 = 1'b1; fsel4 = 2'd2;
    cyc4(4'b0100, 1, 2'd2, 8'hA2);
    cyc4(4'b0100, 1, 2'd2, 8'hA2);
    cyc4(4'b0100, 1, 2'd2, 8'hA2);
    iv4 = 4'b1011;
    cyc4(4'b0000, 0, 2'd0, 8'h00);
    chk("fixed_drop", {31'd0, ov4}, 32'd0);

    // pointer untouched by fixed mode (last rr winner 3)
    mode4 = 1'b0; iv4 = 4'b1111;
    cyc4(4'b0001, 1, 2'd0, 8'hA0);

    // reset while a beat is held; beat is discarded
    cyc4(4'b0010, 0, 2'd0, 8'h00);
    rst4 = 1'b1; or4 = 1'b0;
    cyc4(4'b0000, 0, 2'd0, 8'h00);
    chk("midrst_valid", {31'd0, ov4}, 32'd0);
    chk("midrst_data", {24'd0, od4}, 32'd0);
    rst4 = 1'b0; or4 = 1'b1;
    cyc4(4'b0001, 1, 2'd0, 8'hA0);
    iv4 = 4'b0000;
    cyc4(4'b0000, 0, 2'd0, 8'h00);
    cyc4(4'b0000, 0, 2'd0, 8'h00);

    // 3-channel wrap
    rst3 = 1'b0; or3 = 1'b1;
    for (int r = 0; r < 2; r++) begin
      cyc3(3'b001, 1, 2'd0, 16'hB000);
      cyc3(3'b010, 1, 2'd1, 16'hB001);
      cyc3(3'b100, 1, 2'd2, 16'hB002);
    end
    mode3 = 1'b1; fsel3 = 2'd3;
    cyc3(3'b000, 0, 2'd0, 16'h0000);
    chk("oor_drop3", {31'd0, ov3}, 32'd0);
    cyc3(3'b000, 0, 2'd0, 16'h0000);
    fsel3 = 2'd1;
    cyc3(3'b010, 1, 2'd1, 16'hB001);
    iv3 = 3'b000;
    cyc3(3'b000, 0, 2'd0, 16'h0000);
    cyc3(3'b000, 0, 2'd0, 16'h0000);

    chk("q4_empty", q4.size(), 32'd0);
    chk("q3_empty", q3.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_nx1.md
Name: mux_rr_nx1

Overview:
- Parametrised N-channel to 1 multiplexer; the registered, handshaked successor to the combinational 4x1 mux.
- Each input channel has valid/ready; the single output has valid/ready.
- Two grant modes: round-robin arbitration, or fixed select driven by a select port.
- Sits between multiple producers and one shared downstream consumer in datapath test structures.

Parameters:
- N_CH, 4, number of input channels; legal range 2..16, not required to be a power of two.
- WIDTH, 8, data width per channel in bits.
- SEL_W, $clog2(N_CH), derived localparam giving the channel-index width; not overridable.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- mode  in  1  grant mode: 0 = round-robin, 1 = fixed select.
- fix_sel  in  SEL_W  channel to grant when mode=1.
- in_data  in  N_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N_CH  per-channel valid.
- in_ready  out  N_CH  per-channel ready; at most one bit high per cycle.
- out_data  out  WIDTH  registered output data.
- out_sel  out  SEL_W  index of the channel that supplied out_data.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  downstream accepts the beat.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_sel=0, rr_ptr=N_CH-1, so channel 0 has first priority after reset.
- While rst=1, in_ready is all zeros.
- Load enable: load = !out_valid | out_ready, so the output register is empty or is being drained this cycle.
- Grant in round-robin mode (mode=0): the winner is the first channel with in_valid=1 in the search order rr_ptr+1, rr_ptr+2, ..., rr_ptr, taken modulo N_CH. Wrap is correct for non-power-of-two N_CH.
- Grant in fixed mode (mode=1):
  - winner = fix_sel if in_valid[fix_sel]=1; otherwise no grant.
  - fix_sel >= N_CH means no grant, never X.
- Handshake:
  - in_ready[i] = load & grant_valid & (winner==i); this is combinational from the inputs.
  - An input transfer occurs when in_valid[i] & in_ready[i].
  - An output transfer occurs when out_valid & out_ready.
  - in_valid must not depend combinationally on in_ready.
- Register update on an input transfer: out_data <= channel data, out_sel <= winner, out_valid <= 1.
- Register update when load=1 and there is no grant: out_valid <= 0. out_data and out_sel hold their old values.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_sel and out_valid stay stable and in_ready is all zeros.
- Pointer: rr_ptr <= winner only on an input transfer in mode 0. The pointer does not change in mode 1 or on a cycle with no transfer.
- Latency and throughput: 1 cycle from input transfer to out_valid. Sustained throughput is 1 beat/cycle when out_ready is held high.
- Simultaneous output and input transfer in the same cycle: the new beat replaces the old one, with no bubble and no loss.
- Mode change: takes effect at the next grant decision. A beat already in the output register is never dropped or altered.
- Fairness: in mode 0, with all channels continuously valid and out_ready=1, each channel is granted exactly once every N_CH transfers.
- Reset mid-operation: a held beat is discarded (out_valid=0), and rr_ptr returns to N_CH-1.

Decomposition:
- Shared package mux_pkg holds:
  - typedef/localparams for the mode encoding: MODE_RR=1'b0, MODE_FIXED=1'b1.
  - a function that computes the index width, used for SEL_W.
- One sub-module: rr_arbiter.
  - Parameter: N_CH.
  - Inputs: req, ptr, en. Outputs: gnt_onehot, gnt_idx, gnt_valid.
  - Purely combinational rotate-priority search.
- The top level owns rr_ptr, mode selection, and the output register.

Test Plan:
- Reset, then rst=0, mode=0, in_valid=4'b1111, out_ready=1, in_data channel i = 8'hA0+i -> out_sel sequence 0,1,2,3,0 with out_data A0,A1,A2,A3,A0 on consecutive cycles; in_ready one-hot each cycle.
- mode=0, in_valid=4'b1010, out_ready=1 -> out_sel alternates 1,3,1,3; channels 0 and 2 never receive in_ready.
- Backpressure: one beat loaded (out_data=A2), out_ready=0 for 3 cycles -> out_data=A2 and out_valid=1 stable, in_ready=0000; out_ready=1 -> next beat appears the following cycle.
- mode=1, fix_sel=2, in_valid=4'b1111 -> only channel 2 is granted (out_sel=2 every beat); then fix_sel=2 with in_valid[2]=0 -> out_valid drops to 0 after the held beat drains.
- N_CH=3, WIDTH=16, mode=0, all valid -> out_sel 0,1,2,0,1,2, confirming wrap; fix_sel=3 in mode 1 -> no grant, in_ready=000.
- Reset mid-operation: assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, and the first grant after release is channel 0.
